// File: rtl/loop_seq_pkg.sv
// Shared definitions for the loop table sequencer and the loop FSM it feeds:
// sequencer states, entry field layout, and the level/type encodings.
package loop_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } seq_state_t;

    localparam int ENTRY_SZ_STATE = 48;

    localparam int VALID_BIT  = 0;
    localparam int LEVEL_LSB  = 1;
    localparam int SC_LSB     = 3;
    localparam int NUM_SC_LSB = 8;
    localparam int TYPE_LSB   = 13;
    localparam int TRIG_LSB   = 16;

    localparam int LEVEL_W  = 2;
    localparam int SC_W     = 5;
    localparam int NUM_SC_W = 5;
    localparam int TYPE_W   = 3;
    localparam int TRIG_W   = 32;

    localparam logic [LEVEL_W-1:0] LEVEL_I = 2'd0;
    localparam logic [LEVEL_W-1:0] LEVEL_J = 2'd1;
    localparam logic [LEVEL_W-1:0] LEVEL_K = 2'd2;

    localparam logic [TYPE_W-1:0] TYPE_NONE = 3'd0;
    localparam logic [TYPE_W-1:0] TYPE_INIT = 3'd1;
    localparam logic [TYPE_W-1:0] TYPE_BODY = 3'd2;
    localparam logic [TYPE_W-1:0] TYPE_FINI = 3'd3;

    // Assembles one FSM entry from its fields; unused bits stay zero.
    function automatic logic [ENTRY_SZ_STATE-1:0] make_entry(
        input logic                valid,
        input logic [LEVEL_W-1:0]  level,
        input logic [SC_W-1:0]     sc,
        input logic [NUM_SC_W-1:0] num_sc,
        input logic [TYPE_W-1:0]   typ,
        input logic [TRIG_W-1:0]   trig
    );
        logic [ENTRY_SZ_STATE-1:0] e;
        e = '0;
        e[VALID_BIT]                 = valid;
        e[LEVEL_LSB  +: LEVEL_W]     = level;
        e[SC_LSB     +: SC_W]        = sc;
        e[NUM_SC_LSB +: NUM_SC_W]    = num_sc;
        e[TYPE_LSB   +: TYPE_W]      = typ;
        e[TRIG_LSB   +: TRIG_W]      = trig;
        return e;
    endfunction

endpackage

// File: rtl/loop_table_sequencer_rf.sv
// DEPTH x ENTRY_W register file: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module loop_table_rf #(
    parameter int ENTRY_W = 64,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/loop_table_sequencer.sv
// Serves the host-loaded loop table to the loop FSM, repeats the program and
// resets the FSM between passes. Optional perf counter: SEQ_PERF_CNT_EN.
module loop_table_sequencer
    import loop_seq_pkg::*;
#(
    parameter int ENTRY_W = 64,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int REP_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    output logic               wr_err,
    input  logic [ADDR_W:0]    prog_len,
    input  logic [REP_W-1:0]   rep_cnt,
    input  logic               start,
    input  logic [ADDR_W-1:0]  fsm_smart_ptr,
    input  logic               fsm_done,
    output logic [ENTRY_W-1:0] entry_table,
    output logic               fsm_rst,
    output logic               busy,
    output logic               run_done,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0]        perf_cycles,
`endif
    output logic [REP_W-1:0]   reps_left
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    seq_state_t         state;
    seq_state_t         state_nxt;
    logic [ADDR_W:0]    prog_len_q;
    logic [ENTRY_W-1:0] rd_data;
    logic               start_ok;
    logic               start_bad;
    logic               wr_ok;

    always_comb begin
        start_ok  = (state == IDLE) && start && (prog_len != '0);
        start_bad = (state == IDLE) && start && (prog_len == '0);
        wr_ok     = wr_en && (state == IDLE) && ({1'b0, wr_addr} < DEPTH_L);
    end

    loop_table_rf #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W)
    ) u_rf (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (fsm_smart_ptr),
        .rdata (rd_data)
    );

    // Slots past the program end read as zero so the FSM sees valid=0 and raises done.
    always_comb begin
        entry_table = '0;
        if ((state == RUN) && ({1'b0, fsm_smart_ptr} < prog_len_q)) begin
            entry_table = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fsm_rst   = 1'b1;
        busy      = 1'b1;
        run_done  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_ok) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                fsm_rst = 1'b0;
                if (fsm_done) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (reps_left > REP_W'(1)) begin
                    state_nxt = RUN;
                end else begin
                    run_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (rst) begin
            fsm_rst = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prog_len_q <= '0;
            reps_left  <= '0;
            wr_err     <= 1'b0;
        end else begin
            if (start_ok) begin
                prog_len_q <= prog_len;
                reps_left  <= (rep_cnt == '0) ? REP_W'(1) : rep_cnt;
                wr_err     <= 1'b0;
            end else if (start_bad) begin
                wr_err <= 1'b1;
            end
            if (wr_en && (state != IDLE)) begin
                wr_err <= 1'b1;
            end
            if (state == FLUSH) begin
                reps_left <= reps_left - REP_W'(1);
            end
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (start_ok) begin
            perf_cycles <= '0;
        end else if (((state == RUN) || (state == FLUSH)) && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_loop_table_sequencer.sv
// Directed self-checking bench for loop_table_sequencer; the bench plays the
// loop FSM. Covers perf_cycles too when SEQ_PERF_CNT_EN is defined.
module tb_loop_table_sequencer;
    import loop_seq_pkg::*;

    localparam int ENTRY_W = 64;
    localparam int DEPTH   = 32;
    localparam int ADDR_W  = 5;
    localparam int REP_W   = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               wr_en = 1'b0;
    logic [ADDR_W-1:0]  wr_addr = '0;
    logic [ENTRY_W-1:0] wr_data = '0;
    logic               wr_err;
    logic [ADDR_W:0]    prog_len = '0;
    logic [REP_W-1:0]   rep_cnt = '0;
    logic               start = 1'b0;
    logic [ADDR_W-1:0]  fsm_smart_ptr = '0;
    logic               fsm_done = 1'b0;
    logic [ENTRY_W-1:0] entry_table;
    logic               fsm_rst;
    logic               busy;
    logic               run_done;
    logic [REP_W-1:0]   reps_left;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]        perf_cycles;
`endif

    int checks = 0;
    int errors = 0;

    logic [ENTRY_W-1:0] e0, e1, e2;

    loop_table_sequencer #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .REP_W   (REP_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_err        (wr_err),
        .prog_len      (prog_len),
        .rep_cnt       (rep_cnt),
        .start         (start),
        .fsm_smart_ptr (fsm_smart_ptr),
        .fsm_done      (fsm_done),
        .entry_table   (entry_table),
        .fsm_rst       (fsm_rst),
        .busy          (busy),
        .run_done      (run_done),
`ifdef SEQ_PERF_CNT_EN
        .perf_cycles   (perf_cycles),
`endif
        .reps_left     (reps_left)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Host table write of one slot.
    task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [ENTRY_W-1:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic startRun(input logic [ADDR_W:0] plen, input logic [REP_W-1:0] reps);
        prog_len = plen;
        rep_cnt  = reps;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic endPass();
        fsm_done = 1'b1;
        tick();
        fsm_done = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rst_pulses;
        int done_pulses;

        e0 = {16'b0, make_entry(1'b1, LEVEL_K, 5'd0, 5'd0, TYPE_INIT, 32'd4)};
        e1 = {16'b0, make_entry(1'b1, LEVEL_K, 5'd0, 5'd1, TYPE_BODY, 32'd0)};
        e2 = {16'b0, make_entry(1'b1, LEVEL_J, 5'd2, 5'd3, TYPE_BODY, 32'd9)};

        tick();
        tick();
        checkOutput("rst_entry", entry_table, 64'd0);
        checkOutput("rst_fsm_rst", fsm_rst, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_run_done", run_done, 0);
        checkOutput("rst_wr_err", wr_err, 0);
        checkOutput("rst_reps_left", reps_left, 0);
        rst = 1'b0;
        tick();

        applyStimulus(5'd0, e0);
        applyStimulus(5'd1, e1);
        applyStimulus(5'd2, '0);
        checkOutput("idle_entry_zero", entry_table, 64'd0);

        // Single repetition, program length 2.
        fsm_smart_ptr = 5'd0;
        startRun(6'd2, 8'd1);
        checkOutput("run1_busy", busy, 1);
        checkOutput("run1_fsm_rst", fsm_rst, 0);
        checkOutput("run1_entry0", entry_table, e0);
        checkOutput("run1_reps", reps_left, 1);
        fsm_smart_ptr = 5'd1;
        #1;
        checkOutput("run1_entry1", entry_table, e1);
        fsm_smart_ptr = 5'd2;
        #1;
        checkOutput("run1_entry_end", entry_table, 64'd0);
        fsm_done = 1'b1;
        tick();
        fsm_done = 1'b0;
        checkOutput("run1_flush_rst", fsm_rst, 1);
        checkOutput("run1_run_done", run_done, 1);
        checkOutput("run1_flush_busy", busy, 1);
        tick();
        checkOutput("run1_idle_busy", busy, 0);
        checkOutput("run1_idle_done", run_done, 0);
        checkOutput("run1_idle_reps", reps_left, 0);

        // Three repetitions.
        fsm_smart_ptr = 5'd0;
        rst_pulses  = 0;
        done_pulses = 0;
        startRun(6'd2, 8'd3);
        for (int r = 3; r >= 1; r--) begin
            checkOutput($sformatf("rep3_reps_%0d", r), reps_left, 64'(r));
            checkOutput($sformatf("rep3_run_rst_%0d", r), fsm_rst, 0);
            fsm_done = 1'b1;
            tick();
            fsm_done = 1'b0;
            if (fsm_rst) rst_pulses++;
            if (run_done) done_pulses++;
            tick();
            if (run_done) done_pulses++;
        end
        checkOutput("rep3_rst_pulses", 64'(rst_pulses), 3);
        checkOutput("rep3_done_pulses", 64'(done_pulses), 1);
        checkOutput("rep3_idle_busy", busy, 0);

        // rep_cnt of 0 behaves as 1.
        startRun(6'd2, 8'd0);
        checkOutput("rep0_reps", reps_left, 1);
        fsm_done = 1'b1;
        tick();
        fsm_done = 1'b0;
        checkOutput("rep0_run_done", run_done, 1);
        tick();

        // Write while running is rejected; start while busy is ignored.
        startRun(6'd2, 8'd1);
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 64'hDEAD_BEEF_0000_0001;
        prog_len = 6'd1;
        rep_cnt  = 8'd5;
        start    = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        checkOutput("busy_wr_err", wr_err, 1);
        checkOutput("busy_start_reps", reps_left, 1);
        fsm_smart_ptr = 5'd1;
        #1;
        checkOutput("busy_start_plen", entry_table, e1);
        fsm_smart_ptr = 5'd0;
        endPass();
        checkOutput("wr_err_sticky", wr_err, 1);
        startRun(6'd2, 8'd1);
        checkOutput("wr_err_cleared", wr_err, 0);
        checkOutput("slot0_unchanged", entry_table, e0);
        endPass();

        // Write and start together: the run sees the new slot.
        wr_en   = 1'b1;
        wr_addr = 5'd2;
        wr_data = e2;
        startRun(6'd3, 8'd1);
        wr_en = 1'b0;
        fsm_smart_ptr = 5'd2;
        #1;
        checkOutput("same_cycle_write", entry_table, e2);
        endPass();

        // prog_len masks an occupied slot.
        startRun(6'd2, 8'd1);
        checkOutput("plen_mask", entry_table, 64'd0);
        fsm_smart_ptr = 5'd0;
        endPass();

        // Start with empty program.
        startRun(6'd0, 8'd1);
        checkOutput("plen0_busy", busy, 0);
        checkOutput("plen0_wr_err", wr_err, 1);
        checkOutput("plen0_fsm_rst", fsm_rst, 1);

        // Reset in the second RUN cycle.
        startRun(6'd2, 8'd2);
        tick();
        checkOutput("midrst_in_run", busy, 1);
        rst = 1'b1;
        tick();
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_fsm_rst", fsm_rst, 1);
        checkOutput("midrst_run_done", run_done, 0);
        checkOutput("midrst_entry", entry_table, 64'd0);
        rst = 1'b0;
        tick();

`ifdef SEQ_PERF_CNT_EN
        startRun(6'd2, 8'd1);
        for (int i = 0; i < 5; i++) tick();
        endPass();
        checkOutput("perf_after_run", perf_cycles, 7);
        tick();
        tick();
        checkOutput("perf_held", perf_cycles, 7);
        startRun(6'd2, 8'd1);
        checkOutput("perf_cleared", perf_cycles, 0);
        endPass();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/loop_table_sequencer.md
Name: loop_table_sequencer

Overview:
Owns the state/config table that drives the loop FSM. The host loads loop entries into a local register file through a write port. On start, the block serves entry_table[smart_ptr] to the FSM and detects FSM done. It then pulses an FSM-local reset and either repeats the program or returns to idle with a completion pulse. It sits between the host control path and the loop FSM and is the only writer of the FSM's entry_table input.

Parameters:
ENTRY_W, 64, entry width; must be at least entry_sz_state; bits [47:0] carry the FSM entry format (valid = bit 0).
DEPTH, 32, number of table slots.
ADDR_W, 5, log2(DEPTH); equals dwidth_RFadd.
REP_W, 8, width of the repeat counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_en  in  1  host table write strobe
wr_addr  in  ADDR_W  host write slot
wr_data  in  ENTRY_W  host write entry
wr_err  out  1  sticky: a write was rejected (issued while not IDLE); cleared by rst or start
prog_len  in  ADDR_W+1  number of valid slots (1..DEPTH), sampled at start
rep_cnt  in  REP_W  number of program executions (0 is treated as 1), sampled at start
start  in  1  one-cycle run request
fsm_smart_ptr  in  ADDR_W  smart_ptr from the FSM
fsm_done  in  1  done from the FSM
entry_table  out  ENTRY_W  entry presented to the FSM
fsm_rst  out  1  reset for the FSM (OR'd with rst at instantiation)
busy  out  1  high in every state except IDLE
run_done  out  1  one-cycle pulse when the last repetition completes
reps_left  out  REP_W  repetitions remaining, including the current one

Behaviour:
- Reset values: entry_table=0, fsm_rst=1, busy=0, run_done=0, wr_err=0, reps_left=0, state=IDLE. The table contents are not reset.
- Table writes:
  - Accepted only in IDLE; the slot is written at the clock edge after wr_en.
  - wr_en outside IDLE: no write, and wr_err is set on the next edge.
  - wr_addr greater than or equal to DEPTH: dropped silently.
- entry_table read path:
  - Combinational read of slot fsm_smart_ptr.
  - Forced to all-zero when state is not RUN, or when fsm_smart_ptr is greater than or equal to the latched prog_len. The zero entry (valid=0) is what makes the FSM raise done.
- States:
  - IDLE: fsm_rst=1. On start, latch prog_len and max(rep_cnt,1) into reps_left, clear wr_err, go to RUN. A start while prog_len==0 is ignored and sets wr_err.
  - RUN: fsm_rst=0; entries are served. When fsm_done==1, go to FLUSH.
  - FLUSH: fsm_rst=1 for exactly one cycle, and reps_left decrements. If the pre-decrement value is greater than 1, go to RUN. Otherwise pulse run_done in this cycle and go to IDLE.
- start while busy: ignored, with no side effects.
- Minimum run latency: start at cycle 0, RUN begins at cycle 1, and the first entry is visible at cycle 1.
- Simultaneous start and wr_en in IDLE:
  - The write is accepted in that same cycle.
  - The run begins next cycle and uses the updated table.
- rst mid-run: the block returns to IDLE at the next edge. No run_done is issued. fsm_rst is held high.
- fsm_done while not in RUN: ignored.

Optional Feature:
Macro SEQ_PERF_CNT_EN.
- Defined: adds output perf_cycles (32 bit).
  - Cleared on start.
  - Increments each cycle in RUN or FLUSH, and saturates at all-ones.
  - Holds its value in IDLE until the next start.
- Undefined: the port and counter do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package loop_seq_pkg holds:
  - the state enum (IDLE, RUN, FLUSH);
  - the entry field offsets (VALID_BIT=0, LEVEL_LSB=1, SC_LSB=3, NUM_SC_LSB=8, TYPE_LSB=13, TRIG_LSB=16);
  - the type and level localparams shared with the loop FSM.
- One sub-module, loop_table_rf: DEPTH x ENTRY_W register file with one synchronous write port and one asynchronous read port.

Test Plan:
- Load 3 entries (k-init trig=4; k-body sc=0/num_sc=1; zero), prog_len=2, rep_cnt=1, start → FSM itr_k counts 0..3 then done. fsm_rst pulses one cycle, run_done pulses once, busy falls the next cycle.
- Same program with rep_cnt=3 → exactly 3 fsm_rst pulses in FLUSH; reps_left reads 3,2,1; a single run_done after the third.
- wr_en during RUN at addr 0 → slot 0 unchanged (read back via a later run) and wr_err=1; next start clears wr_err.
- start with prog_len=0 → stays IDLE, busy=0, wr_err=1.
- rst asserted in the 2nd cycle of RUN → next cycle IDLE, fsm_rst=1, no run_done, entry_table=0.
- With SEQ_PERF_CNT_EN, 1-rep run of 6 RUN cycles → perf_cycles=7 (RUN+FLUSH) after return to IDLE, held until the next start.
